// File: rtl/bus_rr_arb.sv
// Round-robin bus arbiter: N hosts share M address-decoded devices, with
// one transaction outstanding at a time, decode-error and timeout responses.
module bus_rr_arb #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned NrDevices     = 3,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrressWidth = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NrHosts-1:0]                 host_req_i,
  input  logic [NrHosts*AddrressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                 host_we_i,
  input  logic [NrHosts*DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                 host_gnt_o,
  output logic [NrHosts-1:0]                 host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                 host_err_o,
  output logic [NrDevices-1:0]               device_req_o,
  output logic [NrDevices*AddrressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]               device_we_o,
  output logic [NrDevices*DataWidth-1:0]     device_wdata_o,
  input  logic [NrDevices-1:0]               device_gnt_i,
  input  logic [NrDevices-1:0]               device_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]     device_rdata_i,
  input  logic [NrDevices-1:0]               device_err_i,
  input  logic [NrDevices*AddrressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices*AddrressWidth-1:0] cfg_device_addr_mask
);

  localparam int unsigned HIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DIdxW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [HIdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HIdxW-1:0]   host_q, host_d;
  logic [DIdxW-1:0]   dev_q, dev_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               decerr_q, decerr_d;

  logic                     sel_found;
  logic [HIdxW-1:0]         sel_host;
  logic [AddrressWidth-1:0] sel_addr;
  logic                     sel_we;
  logic [DataWidth-1:0]     sel_wdata;
  logic                     dev_hit;
  logic [DIdxW-1:0]         dev_sel;
  logic                     dev_gnt;
  logic                     grant_fire;
  logic                     resp_valid;
  logic                     resp_err;
  logic [DataWidth-1:0]     resp_data;

  // Pick the first requesting host at or above rr_ptr, else wrap to the lowest requester.
  always_comb begin
    sel_found = 1'b0;
    sel_host  = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NrHosts; j++) begin
      if (!sel_found && host_req_i[j] && (j >= 32'(rr_ptr_q))) begin
        sel_found = 1'b1;
        sel_host  = HIdxW'(j);
        sel_addr  = host_addr_i[j*AddrressWidth +: AddrressWidth];
        sel_we    = host_we_i[j];
        sel_wdata = host_wdata_i[j*DataWidth +: DataWidth];
      end
    end
    for (int unsigned j = 0; j < NrHosts; j++) begin
      if (!sel_found && host_req_i[j]) begin
        sel_found = 1'b1;
        sel_host  = HIdxW'(j);
        sel_addr  = host_addr_i[j*AddrressWidth +: AddrressWidth];
        sel_we    = host_we_i[j];
        sel_wdata = host_wdata_i[j*DataWidth +: DataWidth];
      end
    end
  end

  // Address decode of the selected host; later matches overwrite, so the highest index wins.
  always_comb begin
    dev_hit = 1'b0;
    dev_sel = '0;
    dev_gnt = 1'b0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if ((sel_addr & cfg_device_addr_mask[d*AddrressWidth +: AddrressWidth]) ==
          cfg_device_addr_base[d*AddrressWidth +: AddrressWidth]) begin
        dev_hit = 1'b1;
        dev_sel = DIdxW'(d);
        dev_gnt = device_gnt_i[d];
      end
    end
    grant_fire = (state_q == IDLE) && sel_found && (dev_hit ? dev_gnt : 1'b1);
  end

  // Response for the recorded host: decode error, device response, or timeout (device wins ties).
  always_comb begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    if (state_q == WAIT_RESP) begin
      if (decerr_q) begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end else begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
          if ((32'(dev_q) == d) && device_rvalid_i[d]) begin
            resp_valid = 1'b1;
            resp_err   = device_err_i[d];
            resp_data  = device_rdata_i[d*DataWidth +: DataWidth];
          end
        end
        if (!resp_valid && (cnt_q == CntW'(TimeoutCycles - 1))) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end
      end
    end
  end

  // Drive host/device outputs; everything is forced low while reset is asserted.
  always_comb begin
    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_rdata_o   = '0;
    host_err_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_wdata_o = '0;
    if (!rst_i) begin
      if ((state_q == IDLE) && sel_found) begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
          if (dev_hit && (32'(dev_sel) == d)) begin
            device_req_o[d]                               = 1'b1;
            device_addr_o[d*AddrressWidth +: AddrressWidth] = sel_addr;
            device_we_o[d]                                = sel_we;
            device_wdata_o[d*DataWidth +: DataWidth]      = sel_wdata;
          end
        end
        for (int unsigned h = 0; h < NrHosts; h++) begin
          if (32'(sel_host) == h) begin
            host_gnt_o[h] = dev_hit ? dev_gnt : 1'b1;
          end
        end
      end
      for (int unsigned h = 0; h < NrHosts; h++) begin
        if (resp_valid && (32'(host_q) == h)) begin
          host_rvalid_o[h]                     = 1'b1;
          host_err_o[h]                        = resp_err;
          host_rdata_o[h*DataWidth +: DataWidth] = resp_data;
        end
      end
    end
  end

  // Next-state logic for the FSM, round-robin pointer and transaction record.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    host_d   = host_q;
    dev_d    = dev_q;
    cnt_d    = cnt_q;
    decerr_d = decerr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_fire) begin
          host_d   = sel_host;
          dev_d    = dev_sel;
          cnt_d    = '0;
          decerr_d = !dev_hit;
          rr_ptr_d = (32'(sel_host) == NrHosts - 1) ? '0 : sel_host + HIdxW'(1);
          state_d  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          decerr_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      host_q   <= '0;
      dev_q    <= '0;
      cnt_q    <= '0;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      host_q   <= host_d;
      dev_q    <= dev_d;
      cnt_q    <= cnt_d;
      decerr_q <= decerr_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_arb.sv
// Directed bench for bus_rr_arb: 2 hosts, 3 devices at 0x0000/0x1000/0x2000, timeout 4.
module tb_bus_rr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [63:0] host_addr, host_wdata, host_rdata;
  logic [2:0]  device_req, device_we, device_gnt, device_rvalid, device_err;
  logic [95:0] device_addr, device_wdata, device_rdata, cfg_base, cfg_mask;

  int n_checks = 0;
  int n_errors = 0;

  bus_rr_arb #(
    .NrHosts(2),
    .NrDevices(3),
    .DataWidth(32),
    .AddrressWidth(32),
    .TimeoutCycles(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .host_req_i(host_req),
    .host_addr_i(host_addr),
    .host_we_i(host_we),
    .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata),
    .host_err_o(host_err),
    .device_req_o(device_req),
    .device_addr_o(device_addr),
    .device_we_o(device_we),
    .device_wdata_o(device_wdata),
    .device_gnt_i(device_gnt),
    .device_rvalid_i(device_rvalid),
    .device_rdata_i(device_rdata),
    .device_err_i(device_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    host_req      = '0;
    host_we       = '0;
    host_addr     = '0;
    host_wdata    = '0;
    device_gnt    = 3'b111;
    device_rvalid = '0;
    device_rdata  = '0;
    device_err    = '0;
    cfg_base      = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    cfg_mask      = {32'h0000_F000, 32'h0000_F000, 32'h0000_F000};

    // Reset: outputs quiet even with requests and responses present
    host_req          = 2'b11;
    host_addr         = {32'h0000_1000, 32'h0000_1000};
    device_rvalid     = 3'b111;
    tick();
    tick();
    check("rst_gnt", 32'(host_gnt), 32'h0);
    check("rst_dreq", 32'(device_req), 32'h0);
    check("rst_rvalid", 32'(host_rvalid), 32'h0);
    check("rst_daddr1", device_addr[63:32], 32'h0);
    check("rst_dwe", 32'(device_we), 32'h0);
    rst           = 1'b0;
    device_rvalid = '0;

    // Round robin: both hosts continuously to device 1
    host_addr = {32'h0000_1008, 32'h0000_1004};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", 32'(host_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_dreq", 32'(device_req), 32'h2);
      check("rr_daddr", device_addr[63:32], (k % 2 == 0) ? 32'h1004 : 32'h1008);
      tick();
      device_rvalid = 3'b010;
      device_rdata[63:32] = 32'hA0 + 32'(k);
      #1;
      check("rr_wait_gnt", 32'(host_gnt), 32'h0);
      check("rr_wait_dreq", 32'(device_req), 32'h0);
      check("rr_rvalid", 32'(host_rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rdata_own", (k % 2 == 0) ? host_rdata[31:0] : host_rdata[63:32], 32'hA0 + 32'(k));
      check("rr_rdata_other", (k % 2 == 0) ? host_rdata[63:32] : host_rdata[31:0], 32'h0);
      check("rr_err", 32'(host_err), 32'h0);
      tick();
      device_rvalid = '0;
    end
    host_req = '0;

    // Write to device 0 with error response (rr_ptr 0)
    host_req         = 2'b01;
    host_addr[31:0]  = 32'h0000_0010;
    host_we          = 2'b01;
    host_wdata[31:0] = 32'hDEAD_BEEF;
    #1;
    check("wr_dreq", 32'(device_req), 32'h1);
    check("wr_dwe", 32'(device_we), 32'h1);
    check("wr_dwdata", device_wdata[31:0], 32'hDEAD_BEEF);
    check("wr_daddr", device_addr[31:0], 32'h10);
    check("wr_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req      = '0;
    host_we       = '0;
    device_rvalid = 3'b001;
    device_err    = 3'b001;
    #1;
    check("wr_rvalid", 32'(host_rvalid), 32'h1);
    check("wr_err", 32'(host_err), 32'h1);
    tick();
    device_rvalid = '0;
    device_err    = '0;

    // Decode error: host 0 at 0x9000 (rr_ptr 1, wraps to host 0)
    host_req        = 2'b01;
    host_addr[31:0] = 32'h0000_9000;
    #1;
    check("de_gnt", 32'(host_gnt), 32'h1);
    check("de_dreq", 32'(device_req), 32'h0);
    tick();
    host_req = '0;
    #1;
    check("de_rvalid", 32'(host_rvalid), 32'h1);
    check("de_err", 32'(host_err), 32'h1);
    check("de_rdata", host_rdata[31:0], 32'h0);
    tick();
    #1;
    check("de_idle_rvalid", 32'(host_rvalid), 32'h0);
    check("de_idle_gnt", 32'(host_gnt), 32'h0);

    // Device 2 stalls grant 3 cycles; rr_ptr stays at host 1
    host_req   = 2'b11;
    host_addr  = {32'h0000_2000, 32'h0000_1000};
    device_gnt = 3'b011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_gnt", 32'(host_gnt), 32'h0);
      check("stall_dreq", 32'(device_req), 32'h4);
      tick();
    end
    device_gnt = 3'b111;
    #1;
    check("stall_gnt_go", 32'(host_gnt), 32'h2);
    check("stall_dreq_go", 32'(device_req), 32'h4);
    tick();
    host_req = '0;

    // Timeout on device 2; stray rvalid from device 0 ignored
    #1;
    check("to_c0", 32'(host_rvalid), 32'h0);
    tick();
    device_rvalid = 3'b001;
    #1;
    check("to_c1_stray", 32'(host_rvalid), 32'h0);
    tick();
    device_rvalid = '0;
    #1;
    check("to_c2", 32'(host_rvalid), 32'h0);
    tick();
    #1;
    check("to_rvalid", 32'(host_rvalid), 32'h2);
    check("to_err", 32'(host_err), 32'h2);
    check("to_rdata", host_rdata[63:32], 32'h0);
    tick();
    device_rvalid       = 3'b100;
    device_rdata[95:64] = 32'h55;
    #1;
    check("to_late_rvalid", 32'(host_rvalid), 32'h0);
    check("to_late_rdata", host_rdata[63:32], 32'h0);
    tick();
    device_rvalid = '0;

    // Response on the timeout cycle: device wins (rr_ptr 0)
    host_req        = 2'b01;
    host_addr[31:0] = 32'h0000_1000;
    #1;
    check("tie_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req = '0;
    tick();
    tick();
    tick();
    device_rvalid       = 3'b010;
    device_rdata[63:32] = 32'hCAFE;
    #1;
    check("tie_rvalid", 32'(host_rvalid), 32'h1);
    check("tie_err", 32'(host_err), 32'h0);
    check("tie_rdata", host_rdata[31:0], 32'hCAFE);
    tick();
    device_rvalid = '0;

    // Reset during WAIT_RESP: no response, rr_ptr back to 0 (was 1)
    host_req = 2'b01;
    #1;
    check("rw_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req            = '0;
    rst                 = 1'b1;
    device_rvalid       = 3'b010;
    device_rdata[63:32] = 32'h77;
    #1;
    check("rw_rst_rvalid", 32'(host_rvalid), 32'h0);
    check("rw_rst_rdata", host_rdata[31:0], 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rw_post_rvalid", 32'(host_rvalid), 32'h0);
    tick();
    device_rvalid = '0;
    host_req      = 2'b11;
    host_addr     = {32'h0000_1000, 32'h0000_1000};
    #1;
    check("rw_rrptr0_gnt", 32'(host_gnt), 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_arb.md
BUS_RR_ARB -- requirements
Module: bus_rr_arb

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of host ports (1..16).
REQ-002 SHALL have parameter NrDevices, default 3, number of device ports (1..16).
REQ-003 SHALL have parameter DataWidth, default 32, data bus width.
REQ-004 SHALL have parameter AddrressWidth, default 32, address bus width.
REQ-005 SHALL have parameter TimeoutCycles, default 16, maximum cycles to wait for a device response (>=1).
REQ-006 SHALL have port clk_i  input  1  clock; one clock, all state updates on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have host ports, per host: host_req_i in 1; host_addr_i in AddrressWidth; host_we_i in 1; host_wdata_i in DataWidth; host_gnt_o out 1; host_rvalid_o out 1; host_rdata_o out DataWidth; host_err_o out 1.
REQ-009 SHALL have device ports, per device: device_req_o out 1; device_addr_o out AddrressWidth; device_we_o out 1; device_wdata_o out DataWidth; device_gnt_i in 1; device_rvalid_i in 1; device_rdata_i in DataWidth; device_err_i in 1.
REQ-010 SHALL have cfg_device_addr_base and cfg_device_addr_mask, input, AddrressWidth per device; device d matches when (addr & mask[d]) == base[d]; the highest matching index wins.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT_RESP; reset state IDLE.
REQ-012 In IDLE, SHALL select the first requesting host, searching from rr_ptr upward with wrap to 0; no requester -> no device request.
REQ-013 In IDLE with a selected host and an address match, SHALL drive device_req_o/addr/we/wdata of the matched device only from that host; all other device outputs 0.
REQ-014 SHALL assert host_gnt_o of the selected host equal to device_gnt_i of the matched device in the same cycle (combinational); all other host_gnt_o 0.
REQ-015 On the grant cycle, SHALL register host index, device index, clear timeout counter, set rr_ptr = (granted host + 1) mod NrHosts, and go to WAIT_RESP.
REQ-016 No address match (decode error): SHALL assert host_gnt_o for the selected host without any device_req_o, record decerr, go to WAIT_RESP.
REQ-017 In WAIT_RESP, SHALL hold all device_req_o and host_gnt_o at 0 (single outstanding transaction).
REQ-018 In WAIT_RESP with decerr, SHALL in the first cycle pulse host_rvalid_o=1, host_err_o=1, host_rdata_o=0 to the recorded host, and go to IDLE.
REQ-019 In WAIT_RESP, device_rvalid_i of the recorded device SHALL pass combinationally to host_rvalid_o of the recorded host, with device_rdata_i and device_err_i; next state IDLE.
REQ-020 Timeout counter SHALL increment each WAIT_RESP cycle without response; at count == TimeoutCycles-1 without rvalid, SHALL pulse host_rvalid_o=1, host_err_o=1, rdata 0 to recorded host, go to IDLE.
REQ-021 Response and timeout in the same cycle: the device response SHALL win (err = device_err_i).
REQ-022 device_rvalid_i in IDLE, or from a non-recorded device, SHALL be ignored (late responses after timeout discarded).
REQ-023 host_rvalid_o, host_err_o, host_rdata_o of non-responding hosts SHALL be 0 in every cycle.
REQ-024 A host holding host_req_i without grant SHALL stay pending; rr_ptr SHALL change only on a grant.
REQ-025 NrHosts == 1 or NrDevices == 1 SHALL use 1-bit index registers with behaviour unchanged.

Reset
REQ-026 On rst_i=1 at a clock edge: state IDLE, rr_ptr 0, timeout counter 0, decerr 0, recorded indices 0.
REQ-027 While rst_i=1, all host_gnt_o, host_rvalid_o, host_err_o, device_req_o, device_we_o SHALL be 0, data/address outputs 0.
REQ-028 Reset during WAIT_RESP SHALL abandon the transaction with no response to the host; later device rvalid SHALL be ignored.

Verification
REQ-029 Hosts 0 and 1 request continuously to device 1 (base 0x1000, mask 0xF000, gnt tied 1, rvalid one cycle later) -> grants alternate 0,1,0,1; each host gets rvalid one cycle after its grant.
REQ-030 Host 0 reads 0x9000 (no match) -> gnt same cycle, no device_req_o, next cycle rvalid=1, err=1, rdata=0; returns to IDLE.
REQ-031 Device 2 grants, never responds, TimeoutCycles=4 -> rvalid=1, err=1 on 4th WAIT_RESP cycle; rvalid from device 2 one cycle later ignored.
REQ-032 device_gnt_i held 0 for 3 cycles -> host_gnt_o 0, device_req_o held, rr_ptr unchanged; gnt on cycle 4 -> grant and state change.
REQ-033 rst_i asserted in WAIT_RESP -> next cycle all outputs 0, rr_ptr 0; device rvalid next cycle produces no host_rvalid_o.
REQ-034 Write with host_we_i=1, wdata 0xDEADBEEF to device 0 -> device_we_o=1, device_wdata_o=0xDEADBEEF, device_err_i=1 on response -> host_err_o=1.
